alp_regq: RTL and testbench
===========================

# alp_regq

Register-file and Q-register slice for one 4-bit ALP data-path slice, directly upstream of the ALU/WMUX stage. It captures the active-low WMUX result, stores it in a scratchpad or the Q shift register, and drives registered active-high A and B operands (`amux_h`, `bmux_h`) back into the ALU on the next cycle. Q shift links cascade between slices for multiply/divide steps. A sticky zero flag samples `wmuxz_l` for microcode branch tests.

## Interface
- `NREG`, 16: scratchpad entries; address width is `$clog2(NREG)`.
- `clk_h` in 1: data-path clock; all state updates on the rising edge.
- `reset_h` in 1: asynchronous, active-high reset.
- `wmux_l` in 4: WMUX result from the ALU stage, active low; data = `~wmux_l`.
- `wmuxz_l` in 1: low when the WMUX result is zero.
- `wr_en_h` in 1: write data into scratchpad entry `wr_addr_h`.
- `wr_addr_h` in AW: scratchpad write address.
- `ra_addr_h`, `rb_addr_h` in AW: A and B read addresses.
- `asel_h` in 2: A source. 0 = scratchpad, 1 = Q, 2 = zero, 3 = hold.
- `bsel_h` in 1: B source. 0 = scratchpad, 1 = Q.
- `q_op_h` in 2: Q operation. 0 = hold, 1 = load data, 2 = shift left, 3 = shift right.
- `q_shl_sin_h` in 1: serial input for a left shift (from the next-lower slice).
- `q_shr_sin_h` in 1: serial input for a right shift (from the next-higher slice).
- `q_shl_sout_h` out 1: equals `q[3]`, combinational from the register.
- `q_shr_sout_h` out 1: equals `q[0]`, combinational from the register.
- `z_ld_h` in 1: load the zero flag from `~wmuxz_l`.
- `z_clr_h` in 1: clear the zero flag; takes priority over `z_ld_h`.
- `amux_h` out 4: registered A operand.
- `bmux_h` out 4: registered B operand.
- `z_h` out 1: zero flag.

## Operation
- Data is defined as `d = ~wmux_l`. Inversion happens at the input; no active-low data is stored.
- Scratchpad write: when `wr_en_h` is 1, entry `wr_addr_h` becomes `d` at the edge.
- Q register updates at the edge according to `q_op_h`:
  - load: `q <= d`.
  - shift left: `q <= {q[2:0], q_shl_sin_h}`.
  - shift right: `q <= {q_shr_sin_h, q[3:1]}`.
  - hold: `q` unchanged.
- The serial-out ports always reflect the current `q`, so chained slices shift in the same edge without a ripple.
- Operand registers show post-edge state:
  - A source 0 is the scratchpad entry at `ra_addr_h`, with forwarding. If `wr_en_h` is 1 and `wr_addr_h == ra_addr_h`, `amux_h <= d`.
  - A source 1 is the post-edge Q value, `amux_h <= q_next`.
  - A source 2 is zero, `amux_h <= 4'b0000`.
  - A source 3 holds `amux_h`.
  - B sources follow the same rules with `rb_addr_h`; B has no hold or zero option.
- Zero flag update:
  - `z_clr_h` = 1: `z_h <= 0`.
  - otherwise `z_ld_h` = 1: `z_h <= ~wmuxz_l`.
  - otherwise `z_h` holds.
- Simultaneous events:
  - Scratchpad write and Q load in the same cycle both take `d`.
  - A and B reading the same address both forward.
  - Write to address X while reading address Y ≠ X: Y returns its old content.
- Reset is asynchronous and clears all scratchpad entries, `q`, `amux_h`, `bmux_h` and `z_h` to 0. The serial outputs are therefore 0 during reset. Reset asserted mid-shift aborts the shift; after reset deasserts, the first edge acts on the inputs normally.

## Timing
- Write-to-read latency is 0 cycles with forwarding: data written at edge N appears on `amux_h` or `bmux_h` immediately after edge N if addressed.
- Read latency is 1 edge: address and select are presented in cycle N, and the operand is valid after edge N. The ALU consumes it in cycle N+1.
- All inputs must be stable by setup before the rising edge. The block has no handshake; every cycle is an issue.
- `q_shl_sout_h` and `q_shr_sout_h` are flop outputs with no combinational path from any input.
- Out-of-range addresses occur only when `NREG` is not a power of two. Such writes are dropped and such reads return 0.

## Structure
- Shared package `alp_pkg` holds:
  - the `asel`, `bsel` and `q_op` encodings as localparams: `ALP_ASEL_RF/Q/ZERO/HOLD`, `ALP_BSEL_RF/Q`, `ALP_QOP_HOLD/LOAD/SHL/SHR`;
  - the slice width constant `ALP_SLICE_W = 4`.
- One sub-module, `alp_qreg`: the Q shift register with its serial links.
- The scratchpad array, forwarding logic, operand registers and zero flag stay inline in `alp_regq`.

## Test plan
- Reset: assert `reset_h` mid-cycle. All outputs go to 0 asynchronously, and entry 5 then reads back 0.
- Write with forwarding: `wmux_l=4'b0101`, `wr_en_h=1`, `wr_addr_h=3`, `ra_addr_h=3`, `asel=RF` give `amux_h=4'hA` after the same edge. Next cycle, with `wr_en_h=0`, it still reads `4'hA`.
- Q shift chain:
  - Load Q with `4'h9`.
  - Shift left with `sin=1` gives `q=4'h3` and `q_shl_sout_h=0`.
  - Shift right with `sin=0` gives `q=4'h1`.
- Q to A and B: `q_op=LOAD`, data `4'h6`, `asel=Q`, `bsel=Q` give `amux_h=bmux_h=4'h6` after the same edge.
- Conflict:
  - Write `4'hF` to entry 2 while A reads 2 and B reads 7, where entry 7 holds `4'h4`.
  - Result: `amux_h=4'hF`, `bmux_h=4'h4`.
- Zero flag:
  - `wmuxz_l=0` with `z_ld_h=1` gives `z_h=1`.
  - `z_clr_h=1` together with `z_ld_h=1` gives `z_h=0`.
  - `asel=HOLD` keeps `amux_h` unchanged across 3 edges.

Source files
------------

// File: rtl/alp_pkg.sv
// Shared encodings and slice width for the ALP data-path slice.
package alp_pkg;

  localparam int unsigned ALP_SLICE_W = 4;

  localparam logic [1:0] ALP_ASEL_RF   = 2'd0;
  localparam logic [1:0] ALP_ASEL_Q    = 2'd1;
  localparam logic [1:0] ALP_ASEL_ZERO = 2'd2;
  localparam logic [1:0] ALP_ASEL_HOLD = 2'd3;

  localparam logic ALP_BSEL_RF = 1'b0;
  localparam logic ALP_BSEL_Q  = 1'b1;

  localparam logic [1:0] ALP_QOP_HOLD = 2'd0;
  localparam logic [1:0] ALP_QOP_LOAD = 2'd1;
  localparam logic [1:0] ALP_QOP_SHL  = 2'd2;
  localparam logic [1:0] ALP_QOP_SHR  = 2'd3;

endpackage

// File: rtl/alp_regq_if.sv
// Per-slice bus between the ALU/WMUX stage (master) and the register/Q slice (slave).
interface alp_regq_if
  import alp_pkg::*;
#(
  parameter int unsigned NREG = 16
);

  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned W  = ALP_SLICE_W;

  logic [W-1:0]  wmux_l;
  logic          wmuxz_l;
  logic          wr_en_h;
  logic [AW-1:0] wr_addr_h;
  logic [AW-1:0] ra_addr_h;
  logic [AW-1:0] rb_addr_h;
  logic [1:0]    asel_h;
  logic          bsel_h;
  logic [1:0]    q_op_h;
  logic          q_shl_sin_h;
  logic          q_shr_sin_h;
  logic          q_shl_sout_h;
  logic          q_shr_sout_h;
  logic          z_ld_h;
  logic          z_clr_h;
  logic [W-1:0]  amux_h;
  logic [W-1:0]  bmux_h;
  logic          z_h;

  modport master (
    output wmux_l, wmuxz_l, wr_en_h, wr_addr_h, ra_addr_h, rb_addr_h,
           asel_h, bsel_h, q_op_h, q_shl_sin_h, q_shr_sin_h, z_ld_h, z_clr_h,
    input  q_shl_sout_h, q_shr_sout_h, amux_h, bmux_h, z_h
  );

  modport slave (
    input  wmux_l, wmuxz_l, wr_en_h, wr_addr_h, ra_addr_h, rb_addr_h,
           asel_h, bsel_h, q_op_h, q_shl_sin_h, q_shr_sin_h, z_ld_h, z_clr_h,
    output q_shl_sout_h, q_shr_sout_h, amux_h, bmux_h, z_h
  );

endinterface

// File: rtl/alp_qreg.sv
// Q shift register for one slice; q_next_c is exposed so operands can show post-edge Q.
module alp_qreg
  import alp_pkg::*;
(
  input  logic                   clk_h,
  input  logic                   reset_h,
  input  logic [1:0]             q_op,
  input  logic [ALP_SLICE_W-1:0] d,
  input  logic                   shl_sin,
  input  logic                   shr_sin,
  output logic [ALP_SLICE_W-1:0] q,
  output logic [ALP_SLICE_W-1:0] q_next_c
);

  localparam int unsigned W = ALP_SLICE_W;

  always_comb begin
    q_next_c = q;
    case (q_op)
      ALP_QOP_HOLD: q_next_c = q;
      ALP_QOP_LOAD: q_next_c = d;
      ALP_QOP_SHL:  q_next_c = {q[W-2:0], shl_sin};
      ALP_QOP_SHR:  q_next_c = {shr_sin, q[W-1:1]};
      default:      q_next_c = q;
    endcase
  end

  always_ff @(posedge clk_h or posedge reset_h) begin
    if (reset_h) q <= '0;
    else         q <= q_next_c;
  end

endmodule

// File: rtl/alp_regq.sv
// Register-file and Q-register slice: scratchpad, Q shifter, forwarded operand
// registers feeding the ALU, and the sticky zero flag.
module alp_regq
  import alp_pkg::*;
#(
  parameter int unsigned NREG = 16
)(
  input  logic        clk_h,
  input  logic        reset_h,
  alp_regq_if.slave   bus
);

  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned W  = ALP_SLICE_W;

  logic [W-1:0] rf [NREG];
  logic [W-1:0] d_c;
  logic [W-1:0] q;
  logic [W-1:0] q_next_c;
  logic [W-1:0] a_rf_c;
  logic [W-1:0] b_rf_c;
  logic [W-1:0] a_next_c;
  logic [W-1:0] b_next_c;
  logic [W-1:0] amux_q;
  logic [W-1:0] bmux_q;
  logic         z_q;
  logic         wr_ok_c;
  logic         ra_ok_c;
  logic         rb_ok_c;
  logic         wr_c;

  assign d_c = ~bus.wmux_l;

  alp_qreg u_qreg (
    .clk_h    (clk_h),
    .reset_h  (reset_h),
    .q_op     (bus.q_op_h),
    .d        (d_c),
    .shl_sin  (bus.q_shl_sin_h),
    .shr_sin  (bus.q_shr_sin_h),
    .q        (q),
    .q_next_c (q_next_c)
  );

  // Serial links come straight off the Q flops so chained slices shift on the same edge.
  assign bus.q_shl_sout_h = q[W-1];
  assign bus.q_shr_sout_h = q[0];

  // Addresses beyond NREG exist only for non-power-of-two depths.
  if (NREG == (32'd1 << AW)) begin : g_pow2
    assign wr_ok_c = 1'b1;
    assign ra_ok_c = 1'b1;
    assign rb_ok_c = 1'b1;
  end else begin : g_npow2
    assign wr_ok_c = (32'(bus.wr_addr_h) < NREG);
    assign ra_ok_c = (32'(bus.ra_addr_h) < NREG);
    assign rb_ok_c = (32'(bus.rb_addr_h) < NREG);
  end

  assign wr_c = bus.wr_en_h && wr_ok_c;

  // Scratchpad read with same-edge write forwarding.
  always_comb begin
    a_rf_c = '0;
    b_rf_c = '0;
    if (ra_ok_c) begin
      a_rf_c = (wr_c && (bus.wr_addr_h == bus.ra_addr_h)) ? d_c : rf[bus.ra_addr_h];
    end
    if (rb_ok_c) begin
      b_rf_c = (wr_c && (bus.wr_addr_h == bus.rb_addr_h)) ? d_c : rf[bus.rb_addr_h];
    end
  end

  always_comb begin
    a_next_c = amux_q;
    case (bus.asel_h)
      ALP_ASEL_RF:   a_next_c = a_rf_c;
      ALP_ASEL_Q:    a_next_c = q_next_c;
      ALP_ASEL_ZERO: a_next_c = '0;
      ALP_ASEL_HOLD: a_next_c = amux_q;
      default:       a_next_c = amux_q;
    endcase
    b_next_c = (bus.bsel_h == ALP_BSEL_Q) ? q_next_c : b_rf_c;
  end

  always_ff @(posedge clk_h or posedge reset_h) begin
    if (reset_h) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wr_c) begin
      rf[bus.wr_addr_h] <= d_c;
    end
  end

  always_ff @(posedge clk_h or posedge reset_h) begin
    if (reset_h) begin
      amux_q <= '0;
      bmux_q <= '0;
    end else begin
      amux_q <= a_next_c;
      bmux_q <= b_next_c;
    end
  end

  // Clear wins over load so microcode can reset the flag unconditionally.
  always_ff @(posedge clk_h or posedge reset_h) begin
    if (reset_h)          z_q <= 1'b0;
    else if (bus.z_clr_h) z_q <= 1'b0;
    else if (bus.z_ld_h)  z_q <= ~bus.wmuxz_l;
  end

  assign bus.amux_h = amux_q;
  assign bus.bmux_h = bmux_q;
  assign bus.z_h    = z_q;

endmodule

// File: tb/tb_alp_regq.sv
// Directed plus random bench for alp_regq using a reference-model scoreboard.
module tb_alp_regq;
  import alp_pkg::*;

  localparam int unsigned NREG = 16;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       z;
    logic       shl;
    logic       shr;
  } obs_t;

  logic clk_h = 1'b0;
  logic reset_h;

  always #5 clk_h = ~clk_h;

  alp_regq_if #(.NREG(NREG)) bus ();

  alp_regq #(.NREG(NREG)) dut (
    .clk_h   (clk_h),
    .reset_h (reset_h),
    .bus     (bus)
  );

  obs_t       exp_q [$];
  logic [3:0] rf_m [NREG];
  logic [3:0] q_m, a_m, b_m;
  logic       z_m;
  int         checks = 0;
  int         errors = 0;

  function automatic obs_t observe();
    return {bus.amux_h, bus.bmux_h, bus.z_h, bus.q_shl_sout_h, bus.q_shr_sout_h};
  endfunction

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NREG); i++) rf_m[i] = 4'h0;
    q_m = 4'h0; a_m = 4'h0; b_m = 4'h0; z_m = 1'b0;
  endtask

  // Drive one cycle's inputs and push the model's post-edge expectation.
  task automatic drive(input logic [3:0] wl, input logic wz, input logic we,
                       input logic [3:0] wa, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [1:0] asel, input logic bsel, input logic [1:0] qop,
                       input logic sl, input logic sr, input logic zl, input logic zc);
    logic [3:0] d, qn, ar, br;
    bus.wmux_l = wl;      bus.wmuxz_l = wz;     bus.wr_en_h = we;
    bus.wr_addr_h = wa;   bus.ra_addr_h = ra;   bus.rb_addr_h = rb;
    bus.asel_h = asel;    bus.bsel_h = bsel;    bus.q_op_h = qop;
    bus.q_shl_sin_h = sl; bus.q_shr_sin_h = sr; bus.z_ld_h = zl; bus.z_clr_h = zc;
    d = ~wl;
    case (qop)
      2'd1:    qn = d;
      2'd2:    qn = {q_m[2:0], sl};
      2'd3:    qn = {sr, q_m[3:1]};
      default: qn = q_m;
    endcase
    ar = (we && wa == ra) ? d : rf_m[ra];
    br = (we && wa == rb) ? d : rf_m[rb];
    case (asel)
      2'd0:    a_m = ar;
      2'd1:    a_m = qn;
      2'd2:    a_m = 4'h0;
      default: a_m = a_m;
    endcase
    b_m = bsel ? qn : br;
    if (zc)      z_m = 1'b0;
    else if (zl) z_m = ~wz;
    if (we) rf_m[wa] = d;
    q_m = qn;
    exp_q.push_back({a_m, b_m, z_m, q_m[3], q_m[0]});
  endtask

  task automatic tick(input string tag);
    obs_t e;
    @(posedge clk_h);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=no_expectation expected=queued_entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, observe(), e);
    end
  endtask

  initial begin
    reset_h = 1'b1;
    bus.wmux_l = 4'hF; bus.wmuxz_l = 1'b1; bus.wr_en_h = 1'b0;
    bus.wr_addr_h = '0; bus.ra_addr_h = '0; bus.rb_addr_h = '0;
    bus.asel_h = ALP_ASEL_RF; bus.bsel_h = ALP_BSEL_RF; bus.q_op_h = ALP_QOP_HOLD;
    bus.q_shl_sin_h = 1'b0; bus.q_shr_sin_h = 1'b0; bus.z_ld_h = 1'b0; bus.z_clr_h = 1'b0;
    model_reset();
    #2;
    check("reset_init", observe(), 11'h000);
    repeat (2) @(negedge clk_h);
    reset_h = 1'b0;

    // Write with forwarding, then plain read-back.
    drive(4'b0101, 1'b1, 1'b1, 4'd3, 4'd3, 4'd0, ALP_ASEL_RF, ALP_BSEL_RF, ALP_QOP_HOLD, 0, 0, 0, 0);
    tick("wr_fwd");
    check("wr_fwd_a", 11'(bus.amux_h), 11'h00A);
    drive(4'hF, 1'b1, 1'b0, 4'd0, 4'd3, 4'd0, ALP_ASEL_RF, ALP_BSEL_RF, ALP_QOP_HOLD, 0, 0, 0, 0);
    tick("rd_back");
    check("rd_back_a", 11'(bus.amux_h), 11'h00A);

    // Q load / shift chain observed through A.
    drive(4'h6, 1'b1, 1'b0, 4'd0, 4'd3, 4'd0, ALP_ASEL_Q, ALP_BSEL_RF, ALP_QOP_LOAD, 0, 0, 0, 0);
    tick("q_load");
    check("q_load_a", 11'(bus.amux_h), 11'h009);
    drive(4'hF, 1'b1, 1'b0, 4'd0, 4'd3, 4'd0, ALP_ASEL_Q, ALP_BSEL_RF, ALP_QOP_SHL, 1, 0, 0, 0);
    tick("q_shl");
    check("q_shl_a", 11'(bus.amux_h), 11'h003);
    check("q_shl_sout", 11'(bus.q_shl_sout_h), 11'h000);
    drive(4'hF, 1'b1, 1'b0, 4'd0, 4'd3, 4'd0, ALP_ASEL_Q, ALP_BSEL_RF, ALP_QOP_SHR, 0, 0, 0, 0);
    tick("q_shr");
    check("q_shr_a", 11'(bus.amux_h), 11'h001);

    // Q to both operands on the load edge.
    drive(4'h9, 1'b1, 1'b0, 4'd0, 4'd3, 4'd0, ALP_ASEL_Q, ALP_BSEL_Q, ALP_QOP_LOAD, 0, 0, 0, 0);
    tick("q_to_ab");
    check("q_to_ab", 11'({bus.amux_h, bus.bmux_h}), 11'h066);

    // Conflict: write entry 2 while B reads untouched entry 7.
    drive(4'hB, 1'b1, 1'b1, 4'd7, 4'd3, 4'd7, ALP_ASEL_RF, ALP_BSEL_RF, ALP_QOP_HOLD, 0, 0, 0, 0);
    tick("wr_e7");
    drive(4'h0, 1'b1, 1'b1, 4'd2, 4'd2, 4'd7, ALP_ASEL_RF, ALP_BSEL_RF, ALP_QOP_HOLD, 0, 0, 0, 0);
    tick("conflict");
    check("conflict_ab", 11'({bus.amux_h, bus.bmux_h}), 11'h0F4);

    // Zero flag load, clear-over-load priority, then A hold.
    drive(4'hF, 1'b0, 1'b0, 4'd0, 4'd2, 4'd7, ALP_ASEL_HOLD, ALP_BSEL_RF, ALP_QOP_HOLD, 0, 0, 1, 0);
    tick("z_ld");
    check("z_ld", 11'(bus.z_h), 11'h001);
    drive(4'hF, 1'b0, 1'b0, 4'd0, 4'd2, 4'd7, ALP_ASEL_HOLD, ALP_BSEL_RF, ALP_QOP_HOLD, 0, 0, 1, 1);
    tick("z_clr");
    check("z_clr", 11'(bus.z_h), 11'h000);
    for (int i = 0; i < 3; i++) begin
      drive(4'hE, 1'b1, 1'b1, 4'd2, 4'd2, 4'd7, ALP_ASEL_HOLD, ALP_BSEL_RF, ALP_QOP_HOLD, 0, 0, 0, 0);
      tick("a_hold");
      check("a_hold", 11'(bus.amux_h), 11'h00F);
    end
    drive(4'hF, 1'b1, 1'b0, 4'd0, 4'd2, 4'd7, ALP_ASEL_ZERO, ALP_BSEL_RF, ALP_QOP_HOLD, 0, 0, 0, 0);
    tick("a_zero");
    check("a_zero", 11'(bus.amux_h), 11'h000);

    // Populate entry 5 and Q, then reset mid-cycle.
    drive(4'h3, 1'b0, 1'b1, 4'd5, 4'd5, 4'd5, ALP_ASEL_RF, ALP_BSEL_RF, ALP_QOP_LOAD, 0, 0, 1, 0);
    tick("pre_reset");
    #3;
    reset_h = 1'b1;
    #1;
    check("reset_async", observe(), 11'h000);
    model_reset();
    @(negedge clk_h);
    reset_h = 1'b0;
    drive(4'hF, 1'b1, 1'b0, 4'd0, 4'd5, 4'd5, ALP_ASEL_RF, ALP_BSEL_RF, ALP_QOP_HOLD, 0, 0, 0, 0);
    tick("post_reset");
    check("rst_entry5", 11'({bus.amux_h, bus.bmux_h}), 11'h000);

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      drive(4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom), 1'($urandom),
            2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
